// File: rtl/game_pkg.sv
// Shared screen identifiers, display geometry and RGB565 colours for the
// game-screen sequencer and its renderers.
package game_pkg;

    localparam int WIDTH_DEF  = 96;
    localparam int HEIGHT_DEF = 64;

    typedef enum logic [2:0] {
        SCR_TITLE = 3'd0,
        SCR_S1    = 3'd1,
        SCR_S2    = 3'd2,
        SCR_S3    = 3'd3,
        SCR_OVER  = 3'd4
    } screen_e;

    localparam logic [15:0] BLACK = 16'h0000;
    localparam logic [15:0] WHITE = 16'hFFFF;
    localparam logic [15:0] RED   = 16'hF800;
    localparam logic [15:0] GREEN = 16'h07E0;
    localparam logic [15:0] BLUE  = 16'h001F;

endpackage

// File: rtl/btn_debounce.sv
// Pushbutton conditioner: 2-flop synchroniser, stability counter and a
// one-cycle pulse on each accepted 0->1 transition.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 62500
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
    output logic rise_o
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          sync1_q, sync2_q;
    logic          level_q, level_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          rise_q, rise_d;

    // Counter only runs while the synchronised input disagrees with the
    // accepted level; any bounce back to agreement restarts it.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        rise_d  = 1'b0;
        if (sync2_q != level_q) begin
            if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
                level_d = sync2_q;
                rise_d  = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
            rise_q  <= 1'b0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            rise_q  <= rise_d;
        end
    end

    assign rise_o = rise_q;

endmodule

// File: rtl/game_screen_sequencer.sv
// Glue between the OLED driver and the static screen renderers: pixel
// coordinates, colour selection and the frame-synchronous game-flow FSM.
//
// state      | meaning
// SCR_TITLE  | title screen, waits for a button press
// SCR_S1..S3 | game screens, press advances (S3 wraps to S1)
// SCR_OVER   | game-over screen, held for HOLD_FRAMES frames
module game_screen_sequencer
    import game_pkg::*;
#(
    parameter int WIDTH           = WIDTH_DEF,
    parameter int HEIGHT          = HEIGHT_DEF,
    parameter int DEBOUNCE_CYCLES = 62500,
    parameter int HOLD_FRAMES     = 120
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [12:0] pixel_index,
    input  logic        frame_begin,
    input  logic        btn_next,
    input  logic        game_over,
    input  logic [15:0] title_data,
    input  logic [15:0] screen1_data,
    input  logic [15:0] screen2_data,
    input  logic [15:0] screen3_data,
    input  logic [15:0] over_data,
    output logic [6:0]  x,
    output logic [5:0]  y,
    output logic [15:0] oled_data,
    output logic [2:0]  screen_id
);
    localparam int HW = $clog2(HOLD_FRAMES + 1);

    screen_e       screen_q, screen_d;
    logic [HW-1:0] hold_q, hold_d;
    logic          pend_q, pend_d;
    logic [6:0]    x_q, x_d;
    logic [5:0]    y_q, y_d;
    logic [15:0]   col_q, col_d;
    logic          rise;
    logic          press;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn (
        .clk    (clk),
        .rst_n  (rst_n),
        .btn_i  (btn_next),
        .rise_o (rise)
    );

    always_comb begin
        x_d = '0;
        y_d = '0;
        if (pixel_index < 13'(WIDTH * HEIGHT)) begin
            x_d = 7'(pixel_index % 13'(WIDTH));
            y_d = 6'(pixel_index / 13'(WIDTH));
        end
    end

    always_comb begin
        unique case (screen_q)
            SCR_TITLE: col_d = title_data;
            SCR_S1:    col_d = screen1_data;
            SCR_S2:    col_d = screen2_data;
            SCR_S3:    col_d = screen3_data;
            SCR_OVER:  col_d = over_data;
            default:   col_d = BLACK;
        endcase
    end

    assign press = rise && (screen_q != SCR_OVER);

    // A press landing on the frame_begin cycle survives into the next frame.
    always_comb begin
        screen_d = screen_q;
        hold_d   = hold_q;
        pend_d   = pend_q | press;
        if (frame_begin) begin
            pend_d = press;
            case (screen_q)
                SCR_TITLE: if (pend_q) screen_d = SCR_S1;
                SCR_S1, SCR_S2, SCR_S3: begin
                    if (game_over) begin
                        screen_d = SCR_OVER;
                        hold_d   = '0;
                    end else if (pend_q) begin
                        screen_d = (screen_q == SCR_S3) ? SCR_S1 : screen_e'(screen_q + 3'd1);
                    end
                end
                SCR_OVER: begin
                    if (hold_q == HW'(HOLD_FRAMES - 1)) begin
                        screen_d = SCR_TITLE;
                        hold_d   = '0;
                    end else begin
                        hold_d = hold_q + 1'b1;
                    end
                end
                default: screen_d = SCR_TITLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            screen_q <= SCR_TITLE;
            hold_q   <= '0;
            pend_q   <= 1'b0;
            x_q      <= '0;
            y_q      <= '0;
            col_q    <= BLACK;
        end else begin
            screen_q <= screen_d;
            hold_q   <= hold_d;
            pend_q   <= pend_d;
            x_q      <= x_d;
            y_q      <= y_d;
            col_q    <= col_d;
        end
    end

    assign x         = x_q;
    assign y         = y_q;
    assign oled_data = col_q;
    assign screen_id = screen_q;

endmodule

// File: tb/tb_game_screen_sequencer.sv
// Directed and randomized checks of the game-screen sequencer against a
// frame-level model of the game flow.
module tb_game_screen_sequencer;

    localparam int DC   = 4;
    localparam int HOLD = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [12:0] pixel_index = '0;
    logic        frame_begin = 1'b0;
    logic        btn_next = 1'b0;
    logic        game_over = 1'b0;
    logic [15:0] title_data, screen1_data, screen2_data, screen3_data, over_data;
    logic [6:0]  x;
    logic [5:0]  y;
    logic [15:0] oled_data;
    logic [2:0]  screen_id;

    int tests = 0;
    int fails = 0;

    int m_scr;
    int m_hold;
    bit m_pend;

    game_screen_sequencer #(
        .DEBOUNCE_CYCLES(DC),
        .HOLD_FRAMES    (HOLD)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pixel_index  (pixel_index),
        .frame_begin  (frame_begin),
        .btn_next     (btn_next),
        .game_over    (game_over),
        .title_data   (title_data),
        .screen1_data (screen1_data),
        .screen2_data (screen2_data),
        .screen3_data (screen3_data),
        .over_data    (over_data),
        .x            (x),
        .y            (y),
        .oled_data    (oled_data),
        .screen_id    (screen_id)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] colour_of(input int s);
        case (s)
            0: return title_data;
            1: return screen1_data;
            2: return screen2_data;
            3: return screen3_data;
            4: return over_data;
            default: return 16'h0000;
        endcase
    endfunction

    // Long enough to be accepted and for the release to settle too.
    task automatic press();
        btn_next = 1'b1;
        repeat (10) tick();
        btn_next = 1'b0;
        repeat (10) tick();
        if (m_scr != 4) m_pend = 1'b1;
    endtask

    task automatic glitch();
        btn_next = 1'b1;
        repeat (3) tick();
        btn_next = 1'b0;
        repeat (10) tick();
    endtask

    // Frame-level game-flow rules.
    task automatic frame();
        if (m_scr == 4) begin
            m_hold++;
            if (m_hold == HOLD) begin
                m_scr  = 0;
                m_hold = 0;
            end
        end else if (game_over && m_scr != 0) begin
            m_scr  = 4;
            m_hold = 0;
        end else if (m_pend) begin
            m_scr = (m_scr == 3) ? 1 : m_scr + 1;
        end
        m_pend = 1'b0;
        frame_begin = 1'b1;
        tick();
        frame_begin = 1'b0;
    endtask

    task automatic pix_check(input logic [12:0] idx, input string tag);
        int ex, ey;
        pixel_index = idx;
        ex = (idx < 6144) ? idx % 96 : 0;
        ey = (idx < 6144) ? idx / 96 : 0;
        tick();
        chk({tag, "_x"}, 32'(x), 32'(ex));
        chk({tag, "_y"}, 32'(y), 32'(ey));
        tick();
        chk({tag, "_col"}, 32'(oled_data), 32'(colour_of(m_scr)));
    endtask

    initial begin
        title_data   = 16'h1000 | 16'($urandom_range(0, 4095));
        screen1_data = 16'h2000 | 16'($urandom_range(0, 4095));
        screen2_data = 16'h3000 | 16'($urandom_range(0, 4095));
        screen3_data = 16'h4000 | 16'($urandom_range(0, 4095));
        over_data    = 16'h5000 | 16'($urandom_range(0, 4095));
        m_scr = 0; m_hold = 0; m_pend = 1'b0;

        #12;
        chk("rst_scr", 32'(screen_id), 32'd0);
        chk("rst_col", 32'(oled_data), 32'h0);
        chk("rst_x", 32'(x), 32'd0);
        chk("rst_y", 32'(y), 32'd0);
        rst_n = 1'b1;
        tick();

        pix_check(13'd0, "p0");
        pix_check(13'd95, "p95");
        pix_check(13'd96, "p96");
        pix_check(13'd6143, "p6143");
        pix_check(13'd6144, "p6144");
        pix_check(13'd8191, "p8191");

        glitch();
        frame();
        chk("glitch", 32'(screen_id), 32'd0);

        press(); frame(); chk("adv1", 32'(screen_id), 32'd1);
        press(); frame(); chk("adv2", 32'(screen_id), 32'd2);
        press(); frame(); chk("adv3", 32'(screen_id), 32'd3);
        press(); frame(); chk("wrap", 32'(screen_id), 32'd1);
        tick();
        chk("wrap_col", 32'(oled_data), 32'(screen1_data));

        press(); press(); frame();
        chk("collapse", 32'(screen_id), 32'd2);
        frame();
        chk("no_stale", 32'(screen_id), 32'd2);

        game_over = 1'b1;
        press(); frame();
        game_over = 1'b0;
        chk("over", 32'(screen_id), 32'd4);
        press(); frame(); chk("hold1", 32'(screen_id), 32'd4);
        press(); frame(); chk("hold2", 32'(screen_id), 32'd4);
        frame();          chk("to_title", 32'(screen_id), 32'd0);
        frame();          chk("title_stay", 32'(screen_id), 32'd0);

        game_over = 1'b1;
        frame();
        chk("go_title", 32'(screen_id), 32'd0);
        game_over = 1'b0;

        press(); frame(); chk("s1b", 32'(screen_id), 32'd1);
        press(); frame(); chk("s2b", 32'(screen_id), 32'd2);
        press();
        chk("mid_scr", 32'(screen_id), 32'd2);
        tick();
        chk("mid_col", 32'(oled_data), 32'(screen2_data));
        frame(); chk("s3b", 32'(screen_id), 32'd3);
        tick();
        chk("s3b_col", 32'(oled_data), 32'(screen3_data));

        rst_n = 1'b0;
        #1;
        chk("arst_scr", 32'(screen_id), 32'd0);
        chk("arst_col", 32'(oled_data), 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        m_scr = 0; m_hold = 0; m_pend = 1'b0;
        tick();
        chk("post_rst_col", 32'(oled_data), 32'(title_data));
        press(); frame(); chk("post_rst_adv", 32'(screen_id), 32'd1);

        for (int f = 0; f < 30; f++) begin
            int np;
            np = $urandom_range(0, 2);
            game_over = ($urandom_range(0, 3) == 0);
            for (int p = 0; p < np; p++) press();
            pix_check(13'($urandom_range(0, 8191)), "rnd_pix");
            frame();
            game_over = 1'b0;
            chk("rnd_scr", 32'(screen_id), 32'(m_scr));
            tick();
            chk("rnd_col", 32'(oled_data), 32'(colour_of(m_scr)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/game_screen_sequencer.md
Name: game_screen_sequencer

Overview:
- Upstream/downstream glue between the OLED display driver and the static game-screen renderers (title, screens 1-3, game-over).
- Converts the driver's pixel_index into registered x/y coordinates for the renderers and selects which renderer's colour is returned as oled_data.
- Owns the game-flow FSM: debounced button advance, game-over entry, timed return to title.
- Screen changes are applied only at frame boundaries, so no frame ever mixes two screens.

Parameters:
- WIDTH, 96, OLED columns
- HEIGHT, 64, OLED rows
- DEBOUNCE_CYCLES, 62500, stable-input cycles needed to accept a button level (10 ms at 6.25 MHz)
- HOLD_FRAMES, 120, frames the GAME_OVER screen is shown before returning to TITLE

Ports:
- clk  in  1  OLED pixel clock (6.25 MHz)
- rst_n  in  1  asynchronous, active-low reset
- pixel_index  in  13  pixel currently requested by the OLED driver, 0..6143
- frame_begin  in  1  one-cycle pulse from the driver at the start of each frame
- btn_next  in  1  raw, unsynchronised pushbutton, active-high
- game_over  in  1  level from game logic; request to enter GAME_OVER
- title_data  in  16  RGB565 colour from the title renderer
- screen1_data  in  16  RGB565 colour from the screen-1 renderer
- screen2_data  in  16  RGB565 colour from the screen-2 renderer
- screen3_data  in  16  RGB565 colour from the screen-3 renderer
- over_data  in  16  RGB565 colour from the game-over renderer
- x  out  7  column to the renderers, 0..95
- y  out  6  row to the renderers, 0..63
- oled_data  out  16  colour returned to the OLED driver
- screen_id  out  3  current screen: 0 = TITLE, 1 = S1, 2 = S2, 3 = S3, 4 = OVER

Behaviour:
- Reset (async assert, sync release): x = 0, y = 0, oled_data = 16'h0000, screen_id = 0 (TITLE), debounce counter = 0, pending request = 0, hold counter = 0.
- Coordinate stage (cycle 1):
  - x <= pixel_index % WIDTH and y <= pixel_index / WIDTH, registered.
  - pixel_index >= 6144 yields x = 0, y = 0.
- Colour stage (cycle 2):
  - oled_data <= data input selected by the current screen_id, registered.
  - Total pixel_index-to-oled_data latency is exactly 2 cycles; the driver compensates.
- Button path:
  - 2-flop synchroniser feeds a debounce counter, which resets on any change of the synchronised level.
  - The accepted level updates when the counter reaches DEBOUNCE_CYCLES-1.
  - A 0->1 transition of the accepted level sets pending_next.
  - Extra presses before the next frame_begin collapse into one request.
- FSM updates only in a cycle where frame_begin = 1:
  - TITLE: pending_next -> S1.
  - S1: game_over -> OVER; else pending_next -> S2.
  - S2: game_over -> OVER; else pending_next -> S3.
  - S3: game_over -> OVER; else pending_next -> S1 (wrap-around).
  - OVER: hold counter increments each frame_begin; at HOLD_FRAMES-1 -> TITLE and the counter clears. Buttons are ignored in OVER.
- Frame-boundary rules:
  - pending_next clears on every frame_begin, whether or not it was consumed.
  - game_over has priority over pending_next.
  - A new press accepted in the same cycle as frame_begin is held for the next frame.
  - game_over in TITLE is ignored.
- The new screen_id is visible from the cycle after frame_begin; the first pixel of that frame uses the new screen.
- rst_n asserted mid-frame forces TITLE and black output immediately.

Decomposition:
- Shared package game_pkg:
  - screen-id constants SCR_TITLE..SCR_OVER (3-bit)
  - WIDTH/HEIGHT defaults
  - RGB565 colour constants (BLACK, WHITE, ...)
- One sub-module, btn_debounce: synchroniser, counter, and rising-edge pulse output; parameter DEBOUNCE_CYCLES. The FSM, coordinate stage and colour mux stay in the top module.

Test Plan:
- Reset, then pixel_index = 0, 95, 96, 6143 -> after 1 cycle (x,y) = (0,0), (95,0), (0,1), (95,63); oled_data = title_data 2 cycles after each index.
- DEBOUNCE_CYCLES = 4: btn_next high for 3 cycles -> no change; held 10 cycles then frame_begin -> screen_id 0->1; 3 more accepted presses across 3 frames -> 2, 3, 1.
- Two accepted presses between consecutive frame_begin pulses -> screen_id advances by exactly 1.
- In S2, assert game_over and an accepted press before frame_begin -> screen_id = 4; HOLD_FRAMES = 3 -> back to 0 after the 3rd subsequent frame_begin; presses during OVER ignored.
- Accepted press mid-frame with no frame_begin -> screen_id and oled_data source unchanged until the next frame_begin pulse.
- rst_n low for 1 cycle while in S3 mid-frame -> screen_id = 0 and oled_data = 0 asynchronously; normal operation resumes after release.
